// File: rtl/vga_pkg.sv
// Shared VGA receiver types and default 640x480@60 timing geometry.
package vga_pkg;

   localparam int HDISP_DEF   = 640;
   localparam int VDISP_DEF   = 480;
   localparam int H_TOTAL_DEF = 800;
   localparam int V_TOTAL_DEF = 525;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      LOCKED
   } rx_state_t;

endpackage

// File: rtl/vga_period_meter.sv
// Saturating event counter; on cap_i the period (including a coincident
// enable) is captured into meas_o and the count restarts from zero.
module vga_period_meter #(
   parameter int W = 10
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic         cap_i,
   output logic [W-1:0] cap_val_o,
   output logic [W-1:0] meas_o
);

   logic [W-1:0] cnt_q, cnt_d, meas_q, meas_d, inc;

   assign inc       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign cap_val_o = en_i ? inc : cnt_q;
   assign meas_o    = meas_q;

   always_comb begin
      cnt_d  = cnt_q;
      meas_d = meas_q;
      if (cap_i) begin
         meas_d = cap_val_o;
         cnt_d  = '0;
      end else if (en_i) begin
         cnt_d = inc;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         meas_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         meas_q <= meas_d;
      end
   end

endmodule

// File: rtl/vga_rx.sv
// VGA raster receiver: registers the port signals, recovers pixel coordinates,
// measures line/frame timing and tracks lock against the expected geometry.
module vga_rx
   import vga_pkg::*;
#(
   parameter int  HDISP   = HDISP_DEF,
   parameter int  VDISP   = VDISP_DEF,
   parameter int  H_TOTAL = H_TOTAL_DEF,
   parameter int  V_TOTAL = V_TOTAL_DEF,
   localparam int HW      = $clog2(H_TOTAL + 1),
   localparam int VW      = $clog2(V_TOTAL + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          VGA_HS,
   input  logic          VGA_VS,
   input  logic          VGA_BLANK,
   input  logic [7:0]    VGA_R,
   input  logic [7:0]    VGA_G,
   input  logic [7:0]    VGA_B,
   output logic          pix_valid,
   output logic [HW-1:0] pix_x,
   output logic [VW-1:0] pix_y,
   output logic [23:0]   pix_rgb,
   output logic          frame_start,
   output logic          locked,
   output logic          err,
   output logic [7:0]    err_cnt,
   output logic [HW-1:0] h_meas,
   output logic [VW-1:0] v_meas
);

   localparam logic [HW-1:0] HDISP_W = HW'(HDISP);
   localparam logic [HW-1:0] HTOT_W  = HW'(H_TOTAL);
   localparam logic [VW-1:0] VDISP_W = VW'(VDISP);
   localparam logic [VW-1:0] VTOT_W  = VW'(V_TOTAL);

   logic hs_q, vs_q, blank_q, hs_p_q, vs_p_q, blank_p_q;
   rgb_t rgb_q, rgb_o_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
         blank_q   <= 1'b0;
         hs_p_q    <= 1'b0;
         vs_p_q    <= 1'b0;
         blank_p_q <= 1'b0;
         rgb_q     <= '0;
      end else begin
         hs_q      <= VGA_HS;
         vs_q      <= VGA_VS;
         blank_q   <= VGA_BLANK;
         hs_p_q    <= hs_q;
         vs_p_q    <= vs_q;
         blank_p_q <= blank_q;
         rgb_q     <= '{r: VGA_R, g: VGA_G, b: VGA_B};
      end
   end

   logic hs_fall, vs_fall, run_end;
   assign hs_fall = hs_p_q & ~hs_q;
   assign vs_fall = vs_p_q & ~vs_q;
   assign run_end = blank_p_q & ~blank_q;

   logic [HW-1:0] h_cap;
   logic [VW-1:0] v_cap;

   vga_period_meter #(.W(HW)) u_line (
      .clk_i(CLK), .rst_i(RST), .en_i(1'b1), .cap_i(hs_fall),
      .cap_val_o(h_cap), .meas_o(h_meas)
   );

   vga_period_meter #(.W(VW)) u_frame (
      .clk_i(CLK), .rst_i(RST), .en_i(hs_fall), .cap_i(vs_fall),
      .cap_val_o(v_cap), .meas_o(v_meas)
   );

   logic [HW-1:0] x_q, x_d;
   logic [VW-1:0] y_q, y_d, y_end;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (blank_q) x_d = (x_q == '1) ? x_q : x_q + 1'b1;
      else if (run_end) x_d = '0;
      if (vs_fall) y_d = '0;
      else if (run_end && y_q != '1) y_d = y_q + 1'b1;
   end

   // A run ending on the vs_fall cycle still counts toward the closing frame.
   assign y_end = y_q + VW'(run_end);

   logic h_bad, run_bad, v_bad, any_bad, fbad_q, fbad_d;
   assign h_bad   = hs_fall && (h_cap != HTOT_W);
   assign run_bad = run_end && (x_q != HDISP_W);
   assign v_bad   = vs_fall && ((v_cap != VTOT_W) || (y_end != VDISP_W));
   assign any_bad = h_bad | run_bad | v_bad;
   assign fbad_d  = vs_fall ? 1'b0 : (fbad_q | h_bad | run_bad);

   rx_state_t state_q, state_d;
   logic      err_d;

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      case (state_q)
         SEARCH:  if (vs_fall) state_d = MEASURE;
         MEASURE: if (vs_fall && !fbad_q && !any_bad) state_d = LOCKED;
         LOCKED: begin
            if (any_bad) begin
               state_d = SEARCH;
               err_d   = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   logic          act;
   logic          pix_valid_q, frame_start_q, err_q;
   logic [HW-1:0] pix_x_q;
   logic [VW-1:0] pix_y_q;
   logic [7:0]    err_cnt_q, err_cnt_d;

   assign act       = blank_q && (state_d == LOCKED);
   assign err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= SEARCH;
         fbad_q        <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         pix_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         rgb_o_q       <= '0;
         err_q         <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         fbad_q        <= fbad_d;
         x_q           <= x_d;
         y_q           <= y_d;
         pix_valid_q   <= act;
         frame_start_q <= act && (x_q == '0) && (y_q == '0);
         pix_x_q       <= x_q;
         pix_y_q       <= y_q;
         rgb_o_q       <= rgb_q;
         err_q         <= err_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_rgb     = rgb_o_q;
   assign frame_start = frame_start_q;
   assign locked      = (state_q == LOCKED);
   assign err         = err_q;
   assign err_cnt     = err_cnt_q;

endmodule
